// File: rtl/dram_pkg.sv
// Shared types and constants for the two-port data RAM arbiter.
package dram_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic RAM_READ  = 1'b1;
  localparam logic RAM_WRITE = 1'b0;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin pick: combinational, no state; rr_ptr breaks ties.
module rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic rr_ptr,
  output logic winner,
  output logic any_req
);

  assign any_req = req0 | req1;
  assign winner  = (req0 & req1) ? rr_ptr : req1;

endmodule

// File: rtl/dram_arbiter.sv
// Serialises port 0 / port 1 accesses to a 256x32 RAM: gnt at k+1, RAM strobe at k+1,
// rvalid/wack at k+2; requesters hold req until gnt, at most one access per 3 cycles.
module dram_arbiter
  import dram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic              wack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic              wack1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_enable,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  state_t              state;
  state_t              state_nxt;
  logic                rr_ptr;
  logic                winner;
  logic                any_req;
  logic                grant;
  logic                win_l;
  logic                we_l;
  logic [ADDR_W-1:0]   addr_l;
  logic [DATA_W-1:0]   wdata_l;

  rr_arbiter2 u_rr (
    .req0    (req0),
    .req1    (req1),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  assign grant = (state == IDLE) && any_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      wack0   <= 1'b0;
      wack1   <= 1'b0;
      rdata   <= '0;
      rr_ptr  <= 1'b0;
      win_l   <= 1'b0;
      we_l    <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
    end else begin
      gnt0    <= grant && !winner;
      gnt1    <= grant && winner;
      rvalid0 <= (state == ACCESS) && !we_l && !win_l;
      rvalid1 <= (state == ACCESS) && !we_l && win_l;
      wack0   <= (state == ACCESS) && we_l && !win_l;
      wack1   <= (state == ACCESS) && we_l && win_l;
      if (grant) begin
        win_l   <= winner;
        we_l    <= winner ? we1    : we0;
        addr_l  <= winner ? addr1  : addr0;
        wdata_l <= winner ? wdata1 : wdata0;
      end
      if ((state == ACCESS) && !we_l) rdata <= ram_dout;
      // Loser of the last access gets the tie-break at the next IDLE.
      if (state == RESP) rr_ptr <= ~win_l;
    end
  end

  // Strobes decode straight from state so reset drops them without waiting for an edge.
  assign ram_enable = (state == ACCESS);
  assign ram_rw     = (ram_enable && we_l) ? RAM_WRITE : RAM_READ;
  assign ram_addr   = addr_l;
  assign ram_din    = wdata_l;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: transaction-level timing/data model plus a RAM behavioural model.
module tb_dram_arbiter;
  import dram_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, we0, gnt0, rvalid0, wack0;
  logic          req1, we1, gnt1, rvalid1, wack1;
  logic [AW-1:0] addr0, addr1, ram_addr;
  logic [DW-1:0] wdata0, wdata1, rdata, ram_din, ram_dout;
  logic          ram_enable, ram_rw, busy;

  dram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .wack0(wack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .wack1(wack1),
    .rdata(rdata), .ram_enable(ram_enable), .ram_rw(ram_rw),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram_mem [256];
  assign ram_dout = ram_mem[ram_addr];
  always @(posedge clk) if (ram_enable && ram_rw == RAM_WRITE) ram_mem[ram_addr] <= ram_din;

  typedef struct packed {
    logic gnt0, gnt1, rv0, rv1, wk0, wk1, en, busy, rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] din, val;
  } exp_t;

  exp_t          ex [4];
  logic [DW-1:0] mdl_mem [256];
  logic [DW-1:0] mdl_rdata;
  logic          pref;
  int            next_arb;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic mdl_reset;
    for (int i = 0; i < 4; i++) ex[i] = '0;
    next_arb  = cyc + 1;
    pref      = 1'b0;
    mdl_rdata = '0;
  endtask

  // Predict what the edge about to come does: one access, then two cycles before the next pick.
  task automatic mdl_eval;
    int e;
    logic w, wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    e = cyc + 1;
    if (e >= next_arb && (req0 || req1)) begin
      w  = (req0 && req1) ? pref : req1;
      wr = w ? we1 : we0;
      a  = w ? addr1 : addr0;
      d  = w ? wdata1 : wdata0;
      ex[2'(e)].gnt0 = !w;
      ex[2'(e)].gnt1 = w;
      ex[2'(e)].en   = 1'b1;
      ex[2'(e)].busy = 1'b1;
      ex[2'(e)].rw   = !wr;
      ex[2'(e)].addr = a;
      ex[2'(e)].din  = d;
      ex[2'(e + 1)].busy = 1'b1;
      if (wr) begin
        mdl_mem[a] = d;
        if (w) ex[2'(e + 1)].wk1 = 1'b1; else ex[2'(e + 1)].wk0 = 1'b1;
      end else begin
        ex[2'(e + 1)].val = mdl_mem[a];
        if (w) ex[2'(e + 1)].rv1 = 1'b1; else ex[2'(e + 1)].rv0 = 1'b1;
      end
      next_arb = e + 3;
      pref     = !w;
    end
  endtask

  task automatic check_cycle;
    exp_t x;
    x = ex[2'(cyc)];
    if (x.rv0 || x.rv1) mdl_rdata = x.val;
    chk("gnt0", gnt0, x.gnt0);
    chk("gnt1", gnt1, x.gnt1);
    chk("rvalid0", rvalid0, x.rv0);
    chk("rvalid1", rvalid1, x.rv1);
    chk("wack0", wack0, x.wk0);
    chk("wack1", wack1, x.wk1);
    chk("ram_enable", ram_enable, x.en);
    chk("busy", busy, x.busy);
    chk("rdata", rdata, mdl_rdata);
    if (x.en) begin
      chk("ram_rw", ram_rw, x.rw);
      chk("ram_addr", ram_addr, x.addr);
      if (!x.rw) chk("ram_din", ram_din, x.din);
    end
    ex[2'(cyc)] = '0;
  endtask

  task automatic step;
    mdl_eval();
    @(posedge clk);
    @(negedge clk);
    check_cycle();
  endtask

  task automatic set0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0 = r; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1 = r; we1 = w; addr1 = a; wdata1 = d;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    #1;
    chk("rst_enable", ram_enable, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rw", ram_rw, 1'b1);
    chk("rst_out", {gnt0, gnt1, rvalid0, rvalid1, wack0, wack1}, 6'd0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_din, 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_resp", {rvalid0, rvalid1, wack0, wack1, ram_enable}, 5'd0);
    end
    rst_n = 1'b1;
    mdl_reset();
  endtask

  int  g0, g1, en_cnt;
  logic pend0, pend1;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 32'h1000_0000 + i;
      mdl_mem[i] = 32'h1000_0000 + i;
    end
    rst_n = 1'b1;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    @(negedge clk);
    apply_reset();

    // port 0 write, then port 1 reads it back
    set0(1, 1, 8'h05, 32'hDEADBEEF);
    step();
    set0(0, 0, 0, 0);
    repeat (3) step();
    chk("mem5", ram_mem[5], 32'hDEADBEEF);
    set1(1, 0, 8'h05, 0);
    step();
    set1(0, 0, 0, 0);
    repeat (3) step();
    chk("rd05", rdata, 32'hDEADBEEF);

    // simultaneous reads straight out of reset
    apply_reset();
    ram_mem[0] = 7; mdl_mem[0] = 7;
    ram_mem[1] = 9; mdl_mem[1] = 9;
    set0(1, 0, 8'h00, 0);
    set1(1, 0, 8'h01, 0);
    step();
    set0(0, 0, 0, 0);
    repeat (3) step();
    set1(0, 0, 0, 0);
    repeat (2) step();
    chk("both_rd_last", rdata, 9);

    // both ports hold req for eight accesses
    g0 = 0; g1 = 0;
    set0(1, 0, 8'h20, 0);
    set1(1, 0, 8'h21, 0);
    repeat (24) begin
      step();
      g0 += int'(gnt0);
      g1 += int'(gnt1);
    end
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    repeat (3) step();
    chk("alt_g0", g0, 4);
    chk("alt_g1", g1, 4);

    // port 1 pulses req only while port 0 is in its access
    g1 = 0; en_cnt = 0;
    set0(1, 0, 8'h03, 0);
    step();
    en_cnt += int'(ram_enable);
    set0(0, 0, 0, 0);
    set1(1, 1, 8'h04, 32'h55);
    step();
    set1(0, 0, 0, 0);
    repeat (4) begin
      step();
      g1 += int'(gnt1);
      en_cnt += int'(ram_enable);
    end
    chk("pulse_gnt1", g1, 0);
    chk("pulse_accesses", en_cnt, 1);

    // reset lands in the middle of a read access
    set0(1, 0, 8'h10, 0);
    step();
    chk("pre_rst_enable", ram_enable, 1'b1);
    apply_reset();
    set0(1, 0, 8'h10, 0);
    step();
    set0(0, 0, 0, 0);
    repeat (3) step();

    // random traffic with hold-until-grant requesters
    pend0 = 1'b0; pend1 = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (gnt0) pend0 = 1'b0;
      if (gnt1) pend1 = 1'b0;
      if (pend0 && $urandom_range(15) == 0) pend0 = 1'b0;
      if (pend1 && $urandom_range(15) == 0) pend1 = 1'b0;
      if (!pend0 && $urandom_range(2) == 0) begin
        pend0 = 1'b1;
        set0(1, 1'($urandom_range(1)), AW'($urandom_range(15)), $urandom);
      end
      if (!pend1 && $urandom_range(2) == 0) begin
        pend1 = 1'b1;
        set1(1, 1'($urandom_range(1)), AW'($urandom_range(15)), $urandom);
      end
      req0 = pend0;
      req1 = pend1;
      step();
    end
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Two-port arbiter and sequencer for the 256x32 data RAM (data_ram256x32).
- Lets the CPU MEM-stage port (port 0) and the loader/debug port (port 1) share one RAM instance.
- Serialises accesses, generates the RAM Enable/ReadWrite strobes and returns read data or write acknowledges to the winning requester.
- Sits between the pipeline MEM stage and the RAM.

Parameters:
ADDR_W, 8, RAM address width (256 words)
DATA_W, 32, RAM word width

Ports:
clk  in  1  single system clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
req0  in  1  port 0 request; held high with its command until gnt0
we0  in  1  port 0 command: 1 = write, 0 = read
addr0  in  ADDR_W  port 0 word address
wdata0  in  DATA_W  port 0 write data
gnt0  out  1  one-cycle pulse; port 0 command accepted and latched
rvalid0  out  1  one-cycle pulse; rdata holds port 0 read result
wack0  out  1  one-cycle pulse; port 0 write committed
req1, we1, addr1, wdata1, gnt1, rvalid1, wack1  same as port 0, for port 1
rdata  out  DATA_W  registered read data, shared by both ports (qualified by rvalidN)
ram_enable  out  1  to RAM Enable
ram_rw  out  1  to RAM ReadWrite: 1 = read, 0 = write
ram_addr  out  ADDR_W  to RAM Address
ram_din  out  DATA_W  to RAM DataIn
ram_dout  in  DATA_W  from RAM DataOut; combinational read, valid in the same cycle as ram_enable
busy  out  1  high in ACCESS and RESP

Behaviour:
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Each state lasts exactly one cycle except IDLE, which holds until a request arrives. One access per 3 cycles at most.
- Reset (async assert, sync release):
  - state = IDLE; rr_ptr = 0 (port 0 preferred first).
  - All outputs 0: gnt*, rvalid*, wack*, ram_enable, busy, rdata, ram_addr, ram_din; ram_rw = 1.
- IDLE, arbitration:
  - No request: stay in IDLE.
  - Exactly one req: that port wins.
  - Both req: the port pointed to by rr_ptr wins.
  - Winner: pulse gnt for one cycle (registered, same edge as entering ACCESS). Latch we/addr/wdata and winner id on that edge.
- ACCESS:
  - ram_enable = 1; ram_rw = ~we_latched; ram_addr and ram_din driven from the latches.
  - On a read, rdata captures ram_dout at the end of this cycle.
  - Write commits in this cycle.
- RESP:
  - ram_enable = 0. Pulse rvalidN (read) or wackN (write) for the winner.
  - rr_ptr = ~winner, so the loser gets priority next time.
  - Next state is IDLE; a new arbitration happens in that IDLE cycle.
- Latency: req seen high in IDLE at edge k gives gnt high during k+1, ram_enable high during k+1, and rvalid/wack high during k+2.
- Requester rules:
  - Command may change only after gnt.
  - Dropping req before gnt withdraws it with no RAM access.
  - req held high after gnt is treated as a new request at the next IDLE.
- rdata holds its value until the next read completes; writes do not alter it.
- Ordering: accesses are strictly serialised. A read issued after another port's write wack returns the new data.
- Reset mid-operation (ACCESS or RESP):
  - Abort immediately; ram_enable drops asynchronously.
  - No rvalid/wack is issued; the requester must reissue.
  - A write already in ACCESS may or may not have committed.
- Address wrap: addr is a full ADDR_W value, so there is no out-of-range case.

Decomposition:
- Shared package dram_pkg holds:
  - state encodings IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2
  - RAM_READ = 1'b1 and RAM_WRITE = 1'b0 constants for ReadWrite
  - ADDR_W and DATA_W defaults
- One natural sub-module: rr_arbiter2, a two-requester round-robin grant function taking req0, req1 and rr_ptr and returning winner and any_req.
- FSM, command latches and RAM drive stay in dram_arbiter.

Test Plan:
- Reset, then port 0 writes 32'hDEADBEEF to 8'h05 -> gnt0 at cycle 1; ram_enable=1, ram_rw=0, ram_addr=05 at cycle 1; wack0 at cycle 2; RAM Mem[5] = DEADBEEF.
- Port 1 reads 8'h05 after the write above -> ram_rw=1 at cycle 1; rvalid1 at cycle 2 with rdata=32'hDEADBEEF; rvalid0 and wack* stay 0.
- req0 and req1 asserted together from reset, both reads of 8'h00/8'h01 preloaded 7 and 9 -> port 0 granted first (rvalid0, rdata=7); port 1 granted next IDLE (rvalid1, rdata=9); total 6 cycles.
- Both ports hold req continuously for 8 accesses -> grants alternate 0,1,0,1...; no port is ever granted twice in a row while the other waits.
- req1 pulsed for one cycle while state = ACCESS for port 0, then dropped -> no gnt1 and no second RAM access; busy falls after RESP.
- rst_n asserted during ACCESS of a port 0 read of 8'h10 -> ram_enable=0 and all outputs 0 immediately; no rvalid0; after release, the first reissued req0 is granted with normal latency.
